spectrum_remapper: RTL and testbench

- Receives the rescaled-bin-index stream produced by the resampler, together with the matching FFT bin values read from spectrum RAM.
- Scatters each bin into a local output frame buffer at its rescaled index.
- After the upstream frame ends, streams one complete frame to the IFFT input. Bins that no index reached are zero-filled.
- Sits between the resampler/spectrum RAM and the IFFT core in the pitch-shift datapath.

---
 rtl/remap_pkg.sv | 34 +++
 rtl/remap_out_stage.sv | 41 ++++
 rtl/spectrum_remapper.sv | 176 +++++++++++++++++
 tb/tb_spectrum_remapper.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remap_pkg.sv
// remap_pkg: shared defaults, state type and saturating-add helper for spectrum_remapper.
package remap_pkg;

  localparam int unsigned DEF_SCALE_FACTOR_INTEGER_WIDTH = 4;
  localparam int unsigned DEF_XK_WIDTH                   = 12;
  localparam int unsigned DEF_BIN_WIDTH                  = 32;
  localparam int unsigned N                              = 2 ** DEF_XK_WIDTH;
  localparam int unsigned IDX_WIDTH = DEF_XK_WIDTH + DEF_SCALE_FACTOR_INTEGER_WIDTH;
  localparam int unsigned DROP_CNT_WIDTH                 = 16;

  typedef enum logic {
    StFill,
    StDrain
  } remap_state_e;

  // Signed add of two sign-extended operands, clamped to a 'width'-bit two's complement range.
  // Callers keep the low 'width' bits of the result.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = $signed(a) + $signed(b);
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sum > max_v) begin
      return max_v;
    end else if (sum < min_v) begin
      return min_v;
    end
    return sum;
  endfunction

endpackage

// File: rtl/remap_out_stage.sv
// remap_out_stage: single registered valid/ready stage; data and last hold under backpressure.
module remap_out_stage #(
  parameter int unsigned Width = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  input  logic             in_last,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  logic [Width-1:0] data_q;
  logic             valid_q;
  logic             last_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

  // Load a new beat whenever the register is empty or its beat is being taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      last_q  <= in_valid && in_last;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/spectrum_remapper.sv
// spectrum_remapper: scatters rescaled-index bins into a local frame buffer, then drains one
// complete zero-filled frame to the IFFT. Optional macro REMAP_ACCUMULATE_EN makes repeated
// hits on an index store a saturating per-half sum instead of last-write-wins.
module spectrum_remapper
  import remap_pkg::*;
#(
  parameter int unsigned SCALE_FACTOR_INTEGER_WIDTH = DEF_SCALE_FACTOR_INTEGER_WIDTH,
  parameter int unsigned XK_WIDTH                   = DEF_XK_WIDTH,
  parameter int unsigned BIN_WIDTH                  = DEF_BIN_WIDTH
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         upstream_valid,
  output logic                                         upstream_ready,
  input  logic [XK_WIDTH+SCALE_FACTOR_INTEGER_WIDTH-1:0] upstream_index,
  input  logic [BIN_WIDTH-1:0]                         upstream_bin,
  input  logic                                         upstream_last,
  output logic [BIN_WIDTH-1:0]                         ifft_tdata,
  output logic                                         ifft_tvalid,
  input  logic                                         ifft_tready,
  output logic                                         ifft_tlast,
  output logic [DROP_CNT_WIDTH-1:0]                    dropped_count
);

  localparam int unsigned NumBins  = 2 ** XK_WIDTH;
  localparam int unsigned IdxWidth = XK_WIDTH + SCALE_FACTOR_INTEGER_WIDTH;

  remap_state_e state_q, state_d;
  logic                      ready_q;
  logic [BIN_WIDTH-1:0]      mem [NumBins];
  logic [NumBins-1:0]        flag_q;
  logic [XK_WIDTH-1:0]       rd_q;
  logic                      issued_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;

  logic                 accept;
  logic                 in_range;
  logic                 wr_en;
  logic [XK_WIDTH-1:0]  wr_addr;
  logic [BIN_WIDTH-1:0] wr_data;
  logic                 src_valid;
  logic                 src_ready;
  logic                 src_last;
  logic                 rd_fire;
  logic [BIN_WIDTH-1:0] src_data;
  logic                 drain_done;

  // ready_q is only ever high in FILL, so it doubles as the fill-state qualifier.
  assign accept         = upstream_valid && ready_q;
  assign in_range       = (upstream_index[IdxWidth-1:XK_WIDTH] == '0);
  assign wr_addr        = upstream_index[XK_WIDTH-1:0];
  assign wr_en          = accept && in_range;
  assign upstream_ready = ready_q;
  assign dropped_count  = drop_q;

  assign src_valid  = (state_q == StDrain) && !issued_q;
  assign rd_fire    = src_valid && src_ready;
  assign src_data   = flag_q[rd_q] ? mem[rd_q] : '0;
  assign src_last   = &rd_q;
  assign drain_done = ifft_tvalid && ifft_tready && ifft_tlast;

`ifdef REMAP_ACCUMULATE_EN
  localparam int unsigned Half = BIN_WIDTH / 2;

  logic                 fwd_valid_q;
  logic [XK_WIDTH-1:0]  fwd_addr_q;
  logic [BIN_WIDTH-1:0] fwd_data_q;
  logic [BIN_WIDTH-1:0] old_bin;
  logic [63:0]          sum_re;
  logic [63:0]          sum_im;

  // Read-modify-write; the forwarded previous write keeps back-to-back hits correct even if
  // the buffer moves to a RAM whose write lands after the next read.
  always_comb begin
    old_bin = mem[wr_addr];
    if (fwd_valid_q && (fwd_addr_q == wr_addr)) begin
      old_bin = fwd_data_q;
    end
    sum_re = sat_add(64'($signed(old_bin[Half-1:0])),
                     64'($signed(upstream_bin[Half-1:0])), Half);
    sum_im = sat_add(64'($signed(old_bin[BIN_WIDTH-1:Half])),
                     64'($signed(upstream_bin[BIN_WIDTH-1:Half])), Half);
    wr_data = flag_q[wr_addr] ? {sum_im[Half-1:0], sum_re[Half-1:0]} : upstream_bin;
  end

  // Remember the last committed write for forwarding.
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_valid_q <= 1'b0;
    end else begin
      fwd_valid_q <= wr_en;
      if (wr_en) begin
        fwd_addr_q <= wr_addr;
        fwd_data_q <= wr_data;
      end
    end
  end
`else
  assign wr_data = upstream_bin;
`endif

  // Frame buffer is not reset; the written flags decide what drains as data or zero.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Written flags: set on fill, cleared as each bin is read out.
  always_ff @(posedge clock) begin
    if (reset) begin
      flag_q <= '0;
    end else begin
      if (wr_en) begin
        flag_q[wr_addr] <= 1'b1;
      end
      if (rd_fire) begin
        flag_q[rd_q] <= 1'b0;
      end
    end
  end

  // Next-state: last accepted pair starts the drain, last accepted output bin ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFill:  if (accept && upstream_last) state_d = StDrain;
      StDrain: if (drain_done) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // State, ready, read counter and drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StFill;
      ready_q  <= 1'b0;
      rd_q     <= '0;
      issued_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StFill);
      if (rd_fire) begin
        rd_q <= rd_q + 1'b1;
        if (src_last) begin
          issued_q <= 1'b1;
        end
      end
      if (drain_done) begin
        issued_q <= 1'b0;
      end
      if (drain_done) begin
        drop_q <= '0;
      end else if (accept && !in_range && !(&drop_q)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  remap_out_stage #(
    .Width(BIN_WIDTH)
  ) u_out_stage (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (src_valid),
    .in_ready  (src_ready),
    .in_data   (src_data),
    .in_last   (src_last),
    .out_data  (ifft_tdata),
    .out_valid (ifft_tvalid),
    .out_ready (ifft_tready),
    .out_last  (ifft_tlast)
  );

endmodule

// File: tb/tb_spectrum_remapper.sv
// tb_spectrum_remapper: randomized scenarios against a frame-level reference model (N=16).
// Expectations follow REMAP_ACCUMULATE_EN when it is defined.
module tb_spectrum_remapper;

  localparam int unsigned NB = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        upstream_valid = 1'b0;
  logic        upstream_ready;
  logic [7:0]  upstream_index = '0;
  logic [31:0] upstream_bin = '0;
  logic        upstream_last = 1'b0;
  logic [31:0] ifft_tdata;
  logic        ifft_tvalid;
  logic        ifft_tready = 1'b1;
  logic        ifft_tlast;
  logic [15:0] dropped_count;

  spectrum_remapper #(
    .SCALE_FACTOR_INTEGER_WIDTH(4),
    .XK_WIDTH                  (4),
    .BIN_WIDTH                 (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .upstream_valid (upstream_valid),
    .upstream_ready (upstream_ready),
    .upstream_index (upstream_index),
    .upstream_bin   (upstream_bin),
    .upstream_last  (upstream_last),
    .ifft_tdata     (ifft_tdata),
    .ifft_tvalid    (ifft_tvalid),
    .ifft_tready    (ifft_tready),
    .ifft_tlast     (ifft_tlast),
    .dropped_count  (dropped_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: what the frame buffer should hold after a frame of pairs.
  logic [31:0] m_mem [NB];
  bit          m_flag [NB];
  int          m_drop;
  int          q_idx [$];
  logic [31:0] q_bin [$];

  // Captured drain.
  logic [31:0] got_data [NB];
  logic        got_last [NB];
  int          got_n, stall_err, ready_err, first_cyc, last_cyc;
  bit          timeout;

`ifdef REMAP_ACCUMULATE_EN
  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    int s;
    logic [31:0] t;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    t = s;
    return t[15:0];
  endfunction
`endif

  function automatic logic [31:0] exp_bin(input int i);
    return m_flag[i] ? m_mem[i] : 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin
      m_flag[i] = 1'b0;
      m_mem[i]  = '0;
    end
    m_drop = 0;
    q_idx.delete();
    q_bin.delete();
  endtask

  task automatic model_pair(input int idx, input logic [31:0] bin);
    if (idx < NB) begin
`ifdef REMAP_ACCUMULATE_EN
      if (m_flag[idx]) m_mem[idx] = {sat16(m_mem[idx][31:16], bin[31:16]),
                                     sat16(m_mem[idx][15:0], bin[15:0])};
      else m_mem[idx] = bin;
`else
      m_mem[idx] = bin;
`endif
      m_flag[idx] = 1'b1;
    end else if (m_drop < 65535) begin
      m_drop++;
    end
  endtask

  // Tasks start and end 1 time unit after a rising edge.
  task automatic send_pair(input int idx, input logic [31:0] bin, input bit last);
    int w;
    w = 0;
    upstream_valid = 1'b1;
    upstream_index = 8'(idx);
    upstream_bin   = bin;
    upstream_last  = last;
    while (upstream_ready !== 1'b1 && w < 200) begin
      @(posedge clock);
      #1;
      w++;
    end
    if (upstream_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout upstream_ready=%b required=1", upstream_ready);
    end else begin
      @(posedge clock);
      #1;
    end
    upstream_valid = 1'b0;
    upstream_last  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < q_idx.size(); i++) begin
      model_pair(q_idx[i], q_bin[i]);
      send_pair(q_idx[i], q_bin[i], i == q_idx.size() - 1);
    end
  endtask

  task automatic drain_frame(input bit rand_ready);
    bit          prev_stall;
    bit          done;
    logic [31:0] pd;
    logic        pl;
    prev_stall = 0;
    done = 0;
    pd = '0;
    pl = 1'b0;
    got_n = 0;
    stall_err = 0;
    ready_err = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int i = 0; i < NB; i++) begin
      got_data[i] = '0;
      got_last[i] = 1'b0;
    end
    for (int c = 0; c < 400 && !done; c++) begin
      ifft_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (upstream_ready !== 1'b0) ready_err++;
      if (prev_stall && (ifft_tvalid !== 1'b1 || ifft_tdata !== pd || ifft_tlast !== pl))
        stall_err++;
      if (ifft_tvalid === 1'b1 && ifft_tready) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        if (got_n < NB) begin
          got_data[got_n] = ifft_tdata;
          got_last[got_n] = ifft_tlast;
        end
        got_n++;
        if (ifft_tlast === 1'b1) done = 1;
      end
      prev_stall = (ifft_tvalid === 1'b1) && !ifft_tready;
      pd = ifft_tdata;
      pl = ifft_tlast;
      @(posedge clock);
      #1;
    end
    ifft_tready = 1'b1;
    timeout = !done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (upstream_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got=%b required=0", upstream_ready);
    end
    n_checks++;
    if (ifft_tvalid !== 1'b0 || ifft_tlast !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_last got=%b%b required=00", ifft_tvalid, ifft_tlast);
    end
    n_checks++;
    if (ifft_tdata !== 32'h0 || dropped_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data_drop got=%h/%h required=0/0", ifft_tdata, dropped_count);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (upstream_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready got=%b required=1", upstream_ready);
    end
  endtask

  task automatic test_scatter_even();
    for (int k = 0; k < 8; k++) send_pair(2 * k, 32'(k + 1), k == 7);
    drain_frame(1'b0);
    n_checks++;
    if (timeout || got_n != NB) begin
      n_fail++; $display("FAIL even_count got=%0d timeout=%0b required=16", got_n, timeout);
    end
    for (int i = 0; i < NB; i++) begin
      n_checks++;
      if (got_data[i] !== ((i % 2 == 0) ? 32'(i / 2 + 1) : 32'h0) || got_last[i] !== (i == 15)) begin
        n_fail++;
        $display("FAIL even_bin[%0d] got=%h last=%b required=%h last=%b", i, got_data[i],
                 got_last[i], (i % 2 == 0) ? 32'(i / 2 + 1) : 32'h0, i == 15);
      end
    end
    n_checks++;
    if (last_cyc - first_cyc != NB - 1) begin
      n_fail++; $display("FAIL even_gaps span=%0d required=15", last_cyc - first_cyc);
    end
    n_checks++;
    if (upstream_ready !== 1'b1 || ready_err != 0) begin
      n_fail++;
      $display("FAIL even_ready after=%b drain_errs=%0d required=1/0", upstream_ready, ready_err);
    end
  endtask

  task automatic test_same_index();
    logic [31:0] want3, want9;
    model_clear();
    q_idx = '{3, 3, 3, 9, 9};
    q_bin = '{32'd5, 32'd6, 32'd7, 32'h8005_7FF0, 32'hFFF0_0020};
    send_frame();
    drain_frame(1'b0);
`ifdef REMAP_ACCUMULATE_EN
    want3 = 32'd18;
    want9 = 32'h8000_7FFF;
`else
    want3 = 32'd7;
    want9 = 32'hFFF0_0020;
`endif
    n_checks++;
    if (got_data[3] !== want3) begin
      n_fail++; $display("FAIL same_bin3 got=%h required=%h", got_data[3], want3);
    end
    n_checks++;
    if (got_data[9] !== want9) begin
      n_fail++; $display("FAIL same_bin9_sat got=%h required=%h", got_data[9], want9);
    end
    for (int i = 0; i < NB; i++) begin
      n_checks++;
      if (got_data[i] !== exp_bin(i)) begin
        n_fail++; $display("FAIL same_bin[%0d] got=%h required=%h", i, got_data[i], exp_bin(i));
      end
    end
  endtask

  task automatic test_dropped();
    logic [31:0] b15;
    b15 = $urandom();
    model_clear();
    q_idx = '{15, 16, 40};
    q_bin = '{b15, $urandom(), $urandom()};
    send_frame();
    n_checks++;
    if (dropped_count !== 16'd2) begin
      n_fail++; $display("FAIL drop_count_drain got=%0d required=2", dropped_count);
    end
    drain_frame(1'b0);
    n_checks++;
    if (got_data[15] !== b15 || got_last[15] !== 1'b1) begin
      n_fail++; $display("FAIL drop_bin15 got=%h required=%h", got_data[15], b15);
    end
    for (int i = 0; i < NB - 1; i++) begin
      n_checks++;
      if (got_data[i] !== 32'h0) begin
        n_fail++; $display("FAIL drop_bin[%0d] got=%h required=0", i, got_data[i]);
      end
    end
    n_checks++;
    if (dropped_count !== 16'd0) begin
      n_fail++; $display("FAIL drop_count_after got=%0d required=0", dropped_count);
    end
  endtask

  task automatic test_backpressure();
    model_clear();
    for (int k = 0; k < 10; k++) begin
      q_idx.push_back(int'($urandom_range(0, NB + 3)));
      q_bin.push_back($urandom());
    end
    send_frame();
    drain_frame(1'b1);
    n_checks++;
    if (timeout || got_n != NB) begin
      n_fail++; $display("FAIL bp_count got=%0d timeout=%0b required=16", got_n, timeout);
    end
    for (int i = 0; i < NB; i++) begin
      n_checks++;
      if (got_data[i] !== exp_bin(i) || got_last[i] !== (i == 15)) begin
        n_fail++; $display("FAIL bp_bin[%0d] got=%h required=%h", i, got_data[i], exp_bin(i));
      end
    end
    n_checks++;
    if (stall_err != 0 || ready_err != 0) begin
      n_fail++; $display("FAIL bp_stable stall_errs=%0d ready_errs=%0d required=0/0",
                         stall_err, ready_err);
    end
  endtask

  task automatic test_reset_mid_drain();
    int acc;
    bit found;
    logic [31:0] b1;
    model_clear();
    for (int k = 0; k < NB; k++) begin
      q_idx.push_back(k);
      q_bin.push_back($urandom() | 32'h1);
    end
    send_frame();
    ifft_tready = 1'b1;
    acc = 0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (ifft_tvalid === 1'b1) begin
        if (acc == 7) found = 1;
        else acc++;
      end
      if (!found) begin
        @(posedge clock);
        #1;
      end
    end
    n_checks++;
    if (!found || ifft_tdata !== exp_bin(7)) begin
      n_fail++; $display("FAIL mid_bin7 got=%h found=%0b required=%h", ifft_tdata, found,
                         exp_bin(7));
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (ifft_tvalid !== 1'b0 || ifft_tlast !== 1'b0 || upstream_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset valid=%b last=%b ready=%b required=0/0/0",
                         ifft_tvalid, ifft_tlast, upstream_ready);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (upstream_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_ready got=%b required=1", upstream_ready);
    end
    b1 = $urandom() | 32'h1;
    model_clear();
    q_idx = '{1};
    q_bin = '{b1};
    send_frame();
    drain_frame(1'b0);
    for (int i = 0; i < NB; i++) begin
      n_checks++;
      if (got_data[i] !== ((i == 1) ? b1 : 32'h0)) begin
        n_fail++; $display("FAIL stale_bin[%0d] got=%h required=%h", i, got_data[i],
                           (i == 1) ? b1 : 32'h0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          b_idx [$];
    logic [31:0] b_bin [$];
    model_clear();
    for (int k = 0; k < 6; k++) begin
      q_idx.push_back(int'($urandom_range(0, NB + 3)));
      q_bin.push_back($urandom());
    end
    for (int k = 0; k < 5; k++) begin
      b_idx.push_back(int'($urandom_range(0, NB - 1)));
      b_bin.push_back($urandom());
    end
    send_frame();
    n_checks++;
    if (dropped_count !== 16'(m_drop)) begin
      n_fail++; $display("FAIL b2b_drop got=%0d required=%0d", dropped_count, m_drop);
    end
    // Next frame's first pair is offered throughout the drain and must wait.
    upstream_valid = 1'b1;
    upstream_index = 8'(b_idx[0]);
    upstream_bin   = b_bin[0];
    upstream_last  = 1'b0;
    drain_frame(1'b1);
    n_checks++;
    if (ready_err != 0 || timeout) begin
      n_fail++; $display("FAIL b2b_hold ready_errs=%0d timeout=%0b required=0/0", ready_err,
                         timeout);
    end
    for (int i = 0; i < NB; i++) begin
      n_checks++;
      if (got_data[i] !== exp_bin(i)) begin
        n_fail++; $display("FAIL b2b_a_bin[%0d] got=%h required=%h", i, got_data[i], exp_bin(i));
      end
    end
    model_clear();
    q_idx = b_idx;
    q_bin = b_bin;
    send_frame();
    drain_frame(1'b0);
    for (int i = 0; i < NB; i++) begin
      n_checks++;
      if (got_data[i] !== exp_bin(i)) begin
        n_fail++; $display("FAIL b2b_b_bin[%0d] got=%h required=%h", i, got_data[i], exp_bin(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_scatter_even();
    test_same_index();
    test_dropped();
    test_backpressure();
    test_reset_mid_drain();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
